// File: rtl/settle_monitor.sv
// Settling/convergence checker: after an optional settle window, every channel must stay
// within +/-tol of its target for hold_cycles consecutive valid samples before a timeout.
module settle_monitor #(
  parameter int unsigned NCH   = 1,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [NCH*WIDTH-1:0] target,
  input  logic [WIDTH-1:0]     tol,
  input  logic [CNT_W-1:0]     settle_cycles,
  input  logic [CNT_W-1:0]     hold_cycles,
  input  logic [CNT_W-1:0]     timeout_cycles,
  input  logic [NCH*WIDTH-1:0] sample,
  input  logic                 sample_vld,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NCH-1:0]       fail_ch
);
  localparam int unsigned EW = WIDTH + 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   RUN_ONE = (CNT_W+1)'(1);

  logic [1:0]           state_q, state_d;
  logic [NCH*WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0]     tol_q, tol_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [CNT_W-1:0]     hold_q, hold_d;
  logic [CNT_W-1:0]     timeout_q, timeout_d;
  logic [CNT_W-1:0]     set_cnt_q, set_cnt_d;
  logic [CNT_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0]     to_cnt_q, to_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [NCH-1:0]       fail_ch_q, fail_ch_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Band test on a WIDTH+1 bit difference so full-scale targets and samples cannot overflow
  logic signed [EW-1:0] err_c;
  logic [EW-1:0]        mag_c;
  logic [NCH-1:0]       oob_c;
  always_comb begin
    err_c = '0;
    mag_c = '0;
    oob_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      err_c    = EW'($signed(sample[i*WIDTH +: WIDTH])) - EW'($signed(tgt_q[i*WIDTH +: WIDTH]));
      mag_c    = err_c[EW-1] ? EW'(-err_c) : EW'(err_c);
      oob_c[i] = (mag_c > {1'b0, tol_q});
    end
  end

  logic [CNT_W-1:0] hold_eff_c;
  logic [CNT_W:0]   run_next_c;
  assign hold_eff_c = (hold_q == '0) ? CNT_ONE : hold_q;
  assign run_next_c = {1'b0, hold_cnt_q} + RUN_ONE;

  logic hit_c;
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    tol_d      = tol_q;
    settle_d   = settle_q;
    hold_d     = hold_q;
    timeout_d  = timeout_q;
    set_cnt_d  = set_cnt_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    pass_d     = pass_q;
    fail_ch_d  = fail_ch_q;
    hit_c      = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            tgt_d      = target;
            tol_d      = tol;
            settle_d   = settle_cycles;
            hold_d     = hold_cycles;
            timeout_d  = timeout_cycles;
            set_cnt_d  = '0;
            hold_cnt_d = '0;
            to_cnt_d   = '0;
            pass_d     = 1'b0;
            fail_ch_d  = '0;
            state_d    = (settle_cycles == '0) ? S_CHECK : S_SETTLE;
          end
        end
        S_SETTLE: begin
          set_cnt_d = sat_inc(set_cnt_q);
          if (set_cnt_q == settle_q - CNT_ONE) state_d = S_CHECK;
        end
        S_CHECK: begin
          to_cnt_d = sat_inc(to_cnt_q);
          if (sample_vld) begin
            if (oob_c == '0) begin
              hold_cnt_d = sat_inc(hold_cnt_q);
              hit_c      = (run_next_c >= {1'b0, hold_eff_c});
            end else begin
              hold_cnt_d = '0;
              fail_ch_d  = oob_c;
            end
          end
          // A qualifying sample on the expiry cycle still counts as a pass
          if (hit_c) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else if ((timeout_q != '0) && (to_cnt_q == timeout_q - CNT_ONE)) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      tol_q      <= '0;
      settle_q   <= '0;
      hold_q     <= '0;
      timeout_q  <= '0;
      set_cnt_q  <= '0;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      tol_q      <= tol_d;
      settle_q   <= settle_d;
      hold_q     <= hold_d;
      timeout_q  <= timeout_d;
      set_cnt_q  <= set_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_ch_q  <= fail_ch_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail_ch = fail_ch_q;
endmodule

// File: doc/settle_monitor.md
# settle_monitor

Parametrised, synthesizable settling/convergence checker for closed-loop signals such as platform angle or wheel speed. It watches NCH signed channels and, once armed, waits a settle window. It then requires every channel to stay within ±tol of its per-channel target for hold_cycles consecutive valid samples before a timeout expires, and reports pass/fail with a per-channel violation mask. It sits beside the balance controller and can be instantiated in toplevel benches or on-chip as a self-test/health monitor.

## Interface
Parameters:
- NCH, 1, number of monitored channels (≥1)
- WIDTH, 16, signed sample/target width
- CNT_W, 24, width of settle/hold/timeout counters

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- arm  input  1  start a check (sampled only in IDLE)
- abort  input  1  cancel check, return to IDLE
- target  input  NCH*WIDTH  signed per-channel targets, channel i at [i*WIDTH +: WIDTH]
- tol  input  WIDTH  unsigned band half-width, shared by all channels
- settle_cycles  input  CNT_W  clocks to wait before checking
- hold_cycles  input  CNT_W  consecutive in-band valid samples required (0 treated as 1)
- timeout_cycles  input  CNT_W  max clocks in CHECK (0 = no timeout)
- sample  input  NCH*WIDTH  signed samples, same packing as target
- sample_vld  input  1  sample qualifier
- busy  output  1  high in SETTLE or CHECK
- done  output  1  one-cycle pulse at end of a completed check
- pass  output  1  result, held until next arm or abort
- fail_ch  output  NCH  channels out of band on the last violating sample

## Operation
- Reset: state IDLE; busy=0, done=0, pass=0, fail_ch=0; all counters 0.
- IDLE: on arm, latch target, tol, settle_cycles, hold_cycles and timeout_cycles. Clear pass, fail_ch, hold_cnt, set_cnt and to_cnt. Go to SETTLE, or directly to CHECK if settle_cycles==0.
- SETTLE: set_cnt increments every clock; samples ignored. Go to CHECK when set_cnt==settle_cycles-1.
- CHECK: to_cnt increments every clock. On sample_vld:
  - per channel, err = sample − target computed at WIDTH+1 bits signed (no overflow); |err| at WIDTH+1 bits unsigned.
  - in-band iff |err| ≤ tol.
  - All channels in band: hold_cnt++. If hold_cnt+1 ≥ max(hold_cycles,1), go to DONE with pass=1.
  - Any channel out of band: hold_cnt=0; fail_ch = out-of-band mask of this sample (overwrites).
  - Without sample_vld, hold_cnt holds; gaps do not break a run.
- Timeout: if timeout_cycles≠0 and to_cnt==timeout_cycles-1 with no pass in that cycle, go to DONE with pass=0.
- DONE: done=1 for exactly one cycle, then IDLE. pass and fail_ch hold.
- abort (any state, priority over everything): next state IDLE; busy=0, pass=0, no done pulse; fail_ch retained.
- arm while busy or in DONE: ignored. arm and abort together in IDLE: abort wins, no start.
- Pass on the same cycle as timeout expiry: pass wins.
- Counters saturate at all-ones, never wrap.
- Asynchronous reset mid-check: immediate return to reset values.

## Timing
- All outputs registered; no combinational input-to-output paths.
- arm sampled at edge t: busy=1 from t+1.
- settle_cycles=N>0: CHECK entered N cycles after SETTLE entry; first sample evaluated is the one valid in CHECK's first cycle.
- The edge that samples the qualifying (hold_cycles-th consecutive) in-band sample is followed one cycle later by done=1, pass=1 and busy=0.
- Timeout: done asserts exactly settle_cycles+timeout_cycles+1 cycles after arm is sampled, counting the DONE cycle.
- Back-to-back: a new arm is accepted the cycle after done (state IDLE).

## Test plan
- NCH=2, WIDTH=16: targets 0/0, tol=250, settle=100, hold=50, timeout=10000; samples ±100 every cycle. Required: done at cycle arm+1+100+50, pass=1, fail_ch=00.
- Same setup, but ch1 sample=300 for cycles 0–19 of CHECK, then 0. Required: pass=1 at CHECK+20+50; the cleared run delays pass; fail_ch=10.
- ch0 stuck at 400, timeout=500. Required: done with pass=0 exactly 100+500+1 cycles after arm; fail_ch=01.
- Extreme values: target=−32768, sample=32767, tol=65535 (WIDTH=16). Required: in-band via the 17-bit difference, no overflow false-pass/fail; tol=0 with sample==target passes.
- abort mid-CHECK, then arm on the following cycle. Required: no done pulse, pass=0, busy drops next cycle; new check runs normally. arm while busy is ignored, with no counter reset.
- sample_vld every 4th cycle, hold=10: pass after the 10th valid in-band sample. Async rst_n pulse mid-SETTLE: all outputs return to 0 immediately.
